// File: rtl/sap_memory_if.sv
// sap_memory_if: W-bus, controller strobe and loader handshake signals for the
// SAP-1 memory stage.
//   master : controller / loader side (drives strobes, bus_in, loader bytes)
//   slave  : sap_memory side (drives bus_out/bus_oe, ld_ready/ld_done, mar_q, busy)
interface sap_memory_if #(
  parameter int WIDTH = 8
);
  logic             n_lm;
  logic             n_ce;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic             prog;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_ready;
  logic             ld_done;
  logic [3:0]       mar_q;
  logic             busy;

  modport master (
    output n_lm, n_ce, bus_in, prog, ld_valid, ld_data,
    input  bus_out, bus_oe, ld_ready, ld_done, mar_q, busy
  );

  modport slave (
    input  n_lm, n_ce, bus_in, prog, ld_valid, ld_data,
    output bus_out, bus_oe, ld_ready, ld_done, mar_q, busy
  );
endinterface

// File: rtl/sap_memory.sv
// sap_memory: SAP-1 memory address register plus 16x8 RAM, with a program
// loader FSM that writes RAM through a valid/ready byte handshake while the
// CPU is held off the bus (busy=1).
// Ports:
//   clk      : clock, all state on posedge
//   rst      : synchronous active-high reset
//   io       : sap_memory_if.slave
//              n_lm/n_ce active-low MAR load / RAM output enable,
//              bus_in (MAR takes [3:0]), bus_out = mem[mar_q], bus_oe,
//              prog level request, ld_valid/ld_data/ld_ready byte handshake,
//              ld_done, mar_q, busy
// Build option:
//   SAP_MEM_CLEAR_EN : adds a CLEAR state that zeroes all 16 words after
//                      reset (16 cycles, busy=1). Undefined: RAM survives reset.
module sap_memory #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  sap_memory_if.slave  io
);
  localparam int AW = 4;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2
`ifdef SAP_MEM_CLEAR_EN
    , S_CLEAR = 2'd3
`endif
  } state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    wcnt;
  logic [AW-1:0]    mar;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             we;
  logic [WIDTH-1:0] wdata;

  // MAR only uses the low nibble of the bus
  logic unused_bus_hi;
  assign unused_bus_hi = ^io.bus_in[WIDTH-1:AW];

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef SAP_MEM_CLEAR_EN
      state <= S_CLEAR;
`else
      state <= S_RUN;
`endif
    end else begin
      state <= state_nx;
    end
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:  if (io.prog) state_nx = S_LOAD;
      // dropping prog wins over a final write; the partial load is kept
      S_LOAD: begin
        if (!io.prog)                        state_nx = S_RUN;
        else if (io.ld_valid && wcnt == LAST) state_nx = S_DONE;
      end
      S_DONE: if (!io.prog) state_nx = S_RUN;
`ifdef SAP_MEM_CLEAR_EN
      S_CLEAR: if (wcnt == LAST) state_nx = S_RUN;
`endif
      default: state_nx = S_RUN;
    endcase
  end

  // outputs
  always_comb begin
    io.ld_ready = (state == S_LOAD);
    io.ld_done  = (state == S_DONE);
    io.busy     = (state != S_RUN);
    io.bus_oe   = (state == S_RUN) && !io.n_ce;
    io.bus_out  = mem[mar];
    io.mar_q    = mar;
  end

  // RAM write port: loader bytes in LOAD, zeros in CLEAR
  always_comb begin
    we    = (state == S_LOAD) && io.ld_valid;
    wdata = io.ld_data;
`ifdef SAP_MEM_CLEAR_EN
    if (state == S_CLEAR) begin
      we    = 1'b1;
      wdata = '0;
    end
`endif
  end

  // no write in a reset cycle, so a reset aborts a session cleanly
  always_ff @(posedge clk) begin
    if (!rst && we) mem[wcnt] <= wdata;
  end

  // write counter: restarts on each load session, steps on every write
  always_ff @(posedge clk) begin
    if (rst)                           wcnt <= '0;
    else if (state == S_RUN && io.prog) wcnt <= '0;
    else if (we)                       wcnt <= wcnt + 1'b1;
  end

  // MAR: prog beats n_lm in RUN; leaving DONE rewinds to address 0
  always_ff @(posedge clk) begin
    if (rst) mar <= '0;
    else begin
      case (state)
        S_RUN:  if (!io.prog && !io.n_lm) mar <= io.bus_in[AW-1:0];
        S_DONE: if (!io.prog)             mar <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sap_memory.sv
// tb_sap_memory: directed self-checking bench for sap_memory. Covers reset
// values, full load, fetch, aborted load, prog/n_lm priority, handshake gaps
// and reset behaviour (clear or retention depending on SAP_MEM_CLEAR_EN).
module tb_sap_memory;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] rd;
  int   cnt;

  always #5 clk = ~clk;

  sap_memory_if #(.WIDTH(8)) io ();

  sap_memory #(.DEPTH(16), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // inputs change 1 time unit after posedge; outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fetch through the MAR in RUN
  task automatic read_mem(input logic [3:0] a, output logic [7:0] d);
    io.n_lm   = 1'b0;
    io.bus_in = {4'h0, a};
    tick();
    io.n_lm = 1'b1;
    io.n_ce = 1'b0;
    #1;
    d = io.bus_out;
    io.n_ce = 1'b1;
  endtask

  // wait out CLEAR (if any); returns cycles spent busy
  task automatic wait_idle(output int c);
    c = 0;
    while (io.busy && c < 40) begin
      tick();
      c++;
    end
  endtask

  task automatic load_all(input logic [7:0] base, input logic same);
    io.prog = 1'b1;
    tick();
    io.ld_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      io.ld_data = same ? base : base + 8'(i);
      tick();
    end
    io.ld_valid = 1'b0;
    io.prog = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    io.n_lm = 1'b1; io.n_ce = 1'b1; io.bus_in = '0;
    io.prog = 1'b0; io.ld_valid = 1'b0; io.ld_data = '0;
    tick(); tick();
    chk("rst_mar", io.mar_q, 4'h0);
    chk("rst_ready", io.ld_ready, 1'b0);
    chk("rst_done", io.ld_done, 1'b0);
    chk("rst_oe", io.bus_oe, 1'b0);
`ifdef SAP_MEM_CLEAR_EN
    chk("rst_busy", io.busy, 1'b1);
`else
    chk("rst_busy", io.busy, 1'b0);
`endif
    rst = 1'b0;
    wait_idle(cnt);
`ifdef SAP_MEM_CLEAR_EN
    chk("init_clear_cycles", cnt, 16);
`endif
    chk("idle_timeout", io.busy, 1'b0);

    // park MAR at 7 to see it hold in LOAD and rewind on exit from DONE
    io.n_lm = 1'b0; io.bus_in = 8'h07;
    tick();
    io.n_lm = 1'b1;
    chk("mar_load", io.mar_q, 4'h7);

    // full load session 0x10..0x1F
    io.prog = 1'b1;
    tick();
    chk("load_ready_rise", io.ld_ready, 1'b1);
    io.ld_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      io.ld_data = 8'h10 + 8'(i);
      if (io.ld_ready) cnt++;
      tick();
    end
    io.ld_valid = 1'b0;
    chk("load_ready_cycles", cnt, 16);
    chk("done_set", io.ld_done, 1'b1);
    chk("done_ready_low", io.ld_ready, 1'b0);
    chk("done_mar_hold", io.mar_q, 4'h7);
    chk("done_busy", io.busy, 1'b1);
    tick();
    chk("done_stays", io.ld_done, 1'b1);
    io.prog = 1'b0;
    tick();
    chk("exit_mar0", io.mar_q, 4'h0);
    chk("exit_busy", io.busy, 1'b0);
    chk("exit_done", io.ld_done, 1'b0);

    // fetch address 5
    io.n_lm = 1'b0; io.bus_in = 8'h05;
    tick();
    io.n_lm = 1'b1;
    chk("fetch_mar", io.mar_q, 4'h5);
    io.n_ce = 1'b0;
    #1;
    chk("fetch_oe", io.bus_oe, 1'b1);
    chk("fetch_data", io.bus_out, 8'h15);
    io.n_ce = 1'b1;
    #1;
    chk("fetch_oe_off", io.bus_oe, 1'b0);
    chk("fetch_data_nooe", io.bus_out, 8'h15);
    read_mem(4'h0, rd); chk("mem0", rd, 8'h10);
    read_mem(4'hF, rd); chk("mem15", rd, 8'h1F);
    chk("mar_after_read", io.mar_q, 4'hF);

    // priority: prog beats n_lm; MAR currently 15, try loading 3
    io.n_lm = 1'b0; io.bus_in = 8'h03; io.prog = 1'b1;
    tick();
    io.n_lm = 1'b1;
    chk("prio_mar", io.mar_q, 4'hF);
    chk("prio_load", io.ld_ready, 1'b1);
    io.n_ce = 1'b0;
    #1;
    chk("load_oe_gated", io.bus_oe, 1'b0);
    io.n_ce = 1'b1;

    // aborted load after AA, BB, CC
    io.ld_valid = 1'b1;
    io.ld_data = 8'hAA; tick();
    io.ld_data = 8'hBB; tick();
    io.ld_data = 8'hCC; tick();
    io.ld_valid = 1'b0; io.prog = 1'b0;
    tick();
    chk("abort_busy", io.busy, 1'b0);
    chk("abort_done", io.ld_done, 1'b0);
    read_mem(4'h0, rd); chk("abort_m0", rd, 8'hAA);
    read_mem(4'h1, rd); chk("abort_m1", rd, 8'hBB);
    read_mem(4'h2, rd); chk("abort_m2", rd, 8'hCC);
    read_mem(4'h3, rd); chk("abort_m3", rd, 8'h13);

    // handshake gaps: valid 1,0,0,1
    io.prog = 1'b1;
    tick();
    io.ld_valid = 1'b1; io.ld_data = 8'h55; tick();
    io.ld_valid = 1'b0; io.ld_data = 8'h66; tick();
    io.ld_valid = 1'b0; io.ld_data = 8'h77; tick();
    io.ld_valid = 1'b1; io.ld_data = 8'h88; tick();
    io.ld_valid = 1'b0; io.prog = 1'b0;
    tick();
    read_mem(4'h0, rd); chk("gap_m0", rd, 8'h55);
    read_mem(4'h1, rd); chk("gap_m1", rd, 8'h88);
    read_mem(4'h2, rd); chk("gap_m2", rd, 8'hCC);
    read_mem(4'h3, rd); chk("gap_m3", rd, 8'h13);

    // preload 0xFF, then reset in the middle of a LOAD write
    load_all(8'hFF, 1'b1);
    read_mem(4'h9, rd); chk("pre_ff", rd, 8'hFF);
    io.prog = 1'b1;
    tick();
    io.ld_valid = 1'b1; io.ld_data = 8'h42;
    rst = 1'b1;
    tick();
    rst = 1'b0; io.ld_valid = 1'b0; io.prog = 1'b0;
    chk("rst2_mar", io.mar_q, 4'h0);
    chk("rst2_ready", io.ld_ready, 1'b0);
`ifdef SAP_MEM_CLEAR_EN
    chk("rst2_busy", io.busy, 1'b1);
    wait_idle(cnt);
    chk("clear_cycles", cnt, 16);
    for (int a = 0; a < 16; a++) begin
      read_mem(4'(a), rd);
      chk($sformatf("clear_m%0d", a), rd, 8'h00);
    end
`else
    chk("rst2_busy", io.busy, 1'b0);
    for (int a = 0; a < 16; a++) begin
      read_mem(4'(a), rd);
      chk($sformatf("keep_m%0d", a), rd, 8'hFF);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
